// File: rtl/cpu_pipe_pkg.sv
// Shared encodings for the pipelined CPU's hazard and branch control:
// strategy codes, PC-select codes, controller states and the control bundle.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        STRAT_NT = 2'b00,
        STRAT_T  = 2'b01,
        STRAT_DS = 2'b10
    } strat_e;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'd0,
        PCSEL_IDT = 2'd1,
        PCSEL_EXT = 2'd2,
        PCSEL_EXF = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        STALL
    } state_e;

    typedef struct packed {
        logic    pc_write;
        logic    ifid_write;
        logic    ifid_flush;
        logic    idex_flush;
        pc_sel_e pc_sel;
    } ctrl_t;

    // Frozen pipeline with bubbles in both registers, and free-flowing sequential fetch.
    localparam ctrl_t CTRL_HOLD = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                    idex_flush: 1'b1, pc_sel: PCSEL_SEQ};
    localparam ctrl_t CTRL_FLOW = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                    idex_flush: 1'b0, pc_sel: PCSEL_SEQ};

    // The reserved code 11 falls back to predict-not-taken.
    function automatic strat_e decode_strategy(input logic [1:0] s);
        return (s == 2'b11) ? STRAT_NT : strat_e'(s);
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Bundle between the IF/ID/EX datapath (master) and the hazard controller (slave):
// instruction status from ID and EX in, stage enables, flushes, PC select and counters out.
interface branch_hazard_ctrl_if #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
);
    logic [1:0]       strategy;
    logic             id_is_branch;
    logic             id_is_jump;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             ex_is_branch;
    logic             ex_taken;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       pc_sel;
    logic [1:0]       mode;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output strategy, id_is_branch, id_is_jump, id_rs, id_rt, id_uses_rs, id_uses_rt,
               ex_memread, ex_rd, ex_is_branch, ex_taken,
        input  pc_write, ifid_write, ifid_flush, idex_flush, pc_sel, mode,
               cycle_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  strategy, id_is_branch, id_is_jump, id_rs, id_rt, id_uses_rs, id_uses_rt,
               ex_memread, ex_rd, ex_is_branch, ex_taken,
        output pc_write, ifid_write, ifid_flush, idex_flush, pc_sel, mode,
               cycle_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds a source the ID
// instruction actually reads. Register 0 never creates a dependency.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    output logic             luse
);
    assign luse = ex_memread && (ex_rd != '0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
endmodule

// File: rtl/branch_hazard_ctrl.sv
// Pipeline control for the pipelined CPU: PC select, IF/ID and ID/EX enables and flushes
// for not-taken, taken and delay-slot branch handling, load-use stalls and perf counters.
module branch_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input logic                 clk,
    input logic                 rst,
    branch_hazard_ctrl_if.slave bus
);
    state_e           state;
    strat_e           mode;
    logic             id_pred;
    logic             ex_pred;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             luse;
    logic             redirect;
    logic             predict_taken;
    ctrl_t            ctrl;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .ex_memread (bus.ex_memread),
        .ex_rd      (bus.ex_rd),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rs (bus.id_uses_rs),
        .id_uses_rt (bus.id_uses_rt),
        .luse       (luse)
    );

    assign redirect = bus.ex_is_branch && (bus.ex_taken != ex_pred);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        ctrl          = CTRL_FLOW;
        predict_taken = 1'b0;
        if (state == INIT) begin
            ctrl = CTRL_HOLD;
        end else if (redirect) begin
            ctrl.pc_sel     = bus.ex_taken ? PCSEL_EXT : PCSEL_EXF;
            ctrl.ifid_flush = 1'b1;
            // In delay-slot mode the instruction now in ID is the slot and must survive.
            ctrl.idex_flush = (mode != STRAT_DS);
        end else if (state == RUN) begin
            if (luse) begin
                ctrl.pc_write   = 1'b0;
                ctrl.ifid_write = 1'b0;
                ctrl.idex_flush = 1'b1;
            end else if (bus.id_is_jump) begin
                ctrl.pc_sel     = PCSEL_IDT;
                ctrl.ifid_flush = (mode != STRAT_DS);
            end else if (bus.id_is_branch && (mode == STRAT_T)) begin
                ctrl.pc_sel     = PCSEL_IDT;
                ctrl.ifid_flush = 1'b1;
                predict_taken   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= INIT;
            mode    <= STRAT_NT;
            id_pred <= 1'b0;
            ex_pred <= 1'b0;
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            case (state)
                INIT: begin
                    mode  <= decode_strategy(bus.strategy);
                    state <= RUN;
                end
                RUN:     state <= ctrl.pc_write ? RUN : STALL;
                default: state <= RUN;
            endcase
            // Prediction bits ride with the instructions; flushes and stalls insert zeros.
            id_pred <= (mode == STRAT_T) &&
                       (predict_taken || (id_pred && !ctrl.ifid_write && !ctrl.ifid_flush));
            ex_pred <= (mode == STRAT_T) && id_pred && ctrl.ifid_write && !ctrl.idex_flush;
            if (state != INIT) begin
                cycle_q <= cycle_q + CNT_W'(1);
                stall_q <= stall_q + CNT_W'(!ctrl.pc_write);
                flush_q <= flush_q + CNT_W'(ctrl.ifid_flush) + CNT_W'(ctrl.idex_flush);
            end
        end
    end

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.ifid_write = ctrl.ifid_write;
    assign bus.ifid_flush = ctrl.ifid_flush;
    assign bus.idex_flush = ctrl.idex_flush;
    assign bus.pc_sel     = ctrl.pc_sel;
    assign bus.mode       = mode;
    assign bus.cycle_cnt  = cycle_q;
    assign bus.stall_cnt  = stall_q;
    assign bus.flush_cnt  = flush_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: constant vector table, directed corner sequences and a
// random run, all cross-checked every cycle against a rule-level reference model.
module tb_branch_hazard_ctrl;
    localparam int CNT_W = 32;
    localparam int REG_W = 5;

    logic clk;
    logic rst;

    branch_hazard_ctrl_if #(.CNT_W(CNT_W), .REG_W(REG_W)) bus ();

    branch_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total;
    int bad;

    // Reference model: instruction-level view of the pipeline control rules.
    bit        m_init;
    bit [1:0]  m_mode;
    bit        m_stalled;
    bit        m_pred_id;
    bit        m_pred_ex;
    bit [31:0] m_cyc;
    bit [31:0] m_stl;
    bit [31:0] m_fl;

    // {pc_write, ifid_write, ifid_flush, idex_flush, pc_sel}
    typedef struct {
        logic       idb;
        logic       idj;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       exm;
        logic [4:0] exrd;
        logic       exb;
        logic       ext;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] dut_ctl();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.pc_sel};
    endfunction

    function automatic bit load_use();
        if (!bus.ex_memread || bus.ex_rd == 5'd0) return 1'b0;
        if (bus.id_uses_rs && bus.id_rs == bus.ex_rd) return 1'b1;
        if (bus.id_uses_rt && bus.id_rt == bus.ex_rd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_inputs();
        bus.id_is_branch = 1'b0;
        bus.id_is_jump   = 1'b0;
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rs   = 1'b0;
        bus.id_uses_rt   = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.ex_rd        = 5'd0;
        bus.ex_is_branch = 1'b0;
        bus.ex_taken     = 1'b0;
    endtask

    task automatic set_vec(input vec_t v);
        bus.id_is_branch = v.idb;
        bus.id_is_jump   = v.idj;
        bus.id_rs        = v.rs;
        bus.id_rt        = v.rt;
        bus.id_uses_rs   = v.urs;
        bus.id_uses_rt   = v.urt;
        bus.ex_memread   = v.exm;
        bus.ex_rd        = v.exrd;
        bus.ex_is_branch = v.exb;
        bus.ex_taken     = v.ext;
    endtask

    task automatic model_reset();
        m_init    = 1'b1;
        m_mode    = 2'b00;
        m_stalled = 1'b0;
        m_pred_id = 1'b0;
        m_pred_ex = 1'b0;
        m_cyc     = 32'd0;
        m_stl     = 32'd0;
        m_fl      = 32'd0;
    endtask

    // Called mid-cycle with inputs settled: checks outputs, advances model and clock.
    task automatic tick(input string tag);
        logic       pcw, ifw, fif, fex, np, mis, lu;
        logic [1:0] sel;
        pcw = 1'b1; ifw = 1'b1; fif = 1'b0; fex = 1'b0; np = 1'b0; mis = 1'b0; lu = 1'b0;
        sel = 2'd0;
        if (m_init) begin
            pcw = 1'b0; ifw = 1'b0; fif = 1'b1; fex = 1'b1;
        end else begin
            mis = bus.ex_is_branch && (bus.ex_taken != m_pred_ex);
            lu  = load_use();
            if (mis) begin
                sel = bus.ex_taken ? 2'd2 : 2'd3;
                fif = 1'b1;
                fex = (m_mode != 2'd2);
            end else if (!m_stalled && lu) begin
                pcw = 1'b0; ifw = 1'b0; fex = 1'b1;
            end else if (!m_stalled && bus.id_is_jump) begin
                sel = 2'd1;
                fif = (m_mode != 2'd2);
            end else if (!m_stalled && bus.id_is_branch && m_mode == 2'd1) begin
                sel = 2'd1; fif = 1'b1; np = 1'b1;
            end
        end
        check({tag, " ctl"}, 64'({dut_ctl(), bus.mode}), 64'({pcw, ifw, fif, fex, sel, m_mode}));
        if (m_init) begin
            m_mode = (bus.strategy == 2'b11) ? 2'b00 : bus.strategy;
            m_init = 1'b0;
        end else begin
            m_cyc     = m_cyc + 32'd1;
            m_stl     = m_stl + {31'd0, ~pcw};
            m_fl      = m_fl + {31'd0, fif} + {31'd0, fex};
            m_stalled = !pcw;
            if (ifw) begin
                m_pred_ex = m_pred_id;
                m_pred_id = 1'b0;
            end else begin
                m_pred_ex = 1'b0;
            end
            if (fex) m_pred_ex = 1'b0;
            if (fif) m_pred_id = 1'b0;
            if (np)  m_pred_id = 1'b1;
            if (m_mode != 2'd1) begin
                m_pred_id = 1'b0;
                m_pred_ex = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check({tag, " cycle_cnt"}, 64'(bus.cycle_cnt), 64'(m_cyc));
        check({tag, " stall_cnt"}, 64'(bus.stall_cnt), 64'(m_stl));
        check({tag, " flush_cnt"}, 64'(bus.flush_cnt), 64'(m_fl));
    endtask

    // Reset, then run the INIT cycle; the strategy is changed afterwards and must be ignored.
    task automatic do_init(input logic [1:0] s);
        rst = 1'b0;
        clear_inputs();
        bus.strategy = s;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #4;
        tick("init");
        bus.strategy = ~s;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear_inputs();
        bus.strategy = 2'b00;
        model_reset();

        vecs[0]  = '{1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 6'b110000};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 6'b111110};
        vecs[2]  = '{1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 6'b110000};
        vecs[3]  = '{1'b0, 1'b0, 5'd20, 5'd1, 1'b1, 1'b0, 1'b1, 5'd20, 1'b0, 1'b0, 6'b000100};
        vecs[4]  = '{1'b0, 1'b0, 5'd2,  5'd7, 1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 6'b000100};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  5'd0, 1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 6'b110000};
        vecs[6]  = '{1'b0, 1'b0, 5'd9,  5'd9, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 6'b110000};
        vecs[7]  = '{1'b0, 1'b0, 5'd9,  5'd9, 1'b1, 1'b1, 1'b0, 5'd9,  1'b0, 1'b0, 6'b110000};
        vecs[8]  = '{1'b0, 1'b1, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 6'b111001};
        vecs[9]  = '{1'b1, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 6'b110000};
        vecs[10] = '{1'b0, 1'b0, 5'd20, 5'd0, 1'b1, 1'b0, 1'b1, 5'd20, 1'b1, 1'b1, 6'b111110};
        vecs[11] = '{1'b0, 1'b1, 5'd3,  5'd0, 1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 6'b000100};
        vecs[12] = '{1'b0, 1'b1, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 6'b111110};

        #3;
        check("reset ctl", 64'({dut_ctl(), bus.mode}), 64'(8'b0011_0000));
        check("reset counters", 64'(bus.cycle_cnt | bus.stall_cnt | bus.flush_cnt), 64'(0));

        // Single-cycle decisions in not-taken mode, each followed by an idle cycle.
        do_init(2'b00);
        for (int i = 0; i < 13; i++) begin
            set_vec(vecs[i]);
            #4;
            check($sformatf("vec%0d", i), 64'(dut_ctl()), 64'(vecs[i].exp));
            tick($sformatf("vec%0d", i));
            clear_inputs();
            #4;
            tick($sformatf("vec%0d idle", i));
        end

        // Predict-taken: redirect to the fall-through only when the prediction was wrong.
        do_init(2'b01);
        for (int pass = 0; pass < 2; pass++) begin
            bus.id_is_branch = 1'b1;
            #4;
            check("taken id beq", 64'(dut_ctl()), 64'(6'b111001));
            tick("taken id beq");
            clear_inputs();
            #4;
            tick("taken gap");
            bus.ex_is_branch = 1'b1;
            bus.ex_taken     = (pass == 1);
            #4;
            check($sformatf("taken ex beq pass%0d", pass), 64'(dut_ctl()),
                  (pass == 0) ? 64'(6'b111111) : 64'(6'b110000));
            tick("taken ex beq");
            clear_inputs();
        end

        // Delay slot: EX redirect keeps ID/EX, jump keeps IF/ID.
        do_init(2'b10);
        bus.ex_is_branch = 1'b1;
        bus.ex_taken     = 1'b1;
        #4;
        check("ds ex taken", 64'(dut_ctl()), 64'(6'b111010));
        tick("ds ex taken");
        clear_inputs();
        bus.id_is_jump = 1'b1;
        #4;
        check("ds jump", 64'(dut_ctl()), 64'(6'b110001));
        tick("ds jump");
        clear_inputs();

        // lw $s4 in EX, slt reading $s4 in ID: one stall cycle.
        do_init(2'b00);
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd20;
        bus.id_rs      = 5'd20;
        bus.id_rt      = 5'd8;
        bus.id_uses_rs = 1'b1;
        bus.id_uses_rt = 1'b1;
        #4;
        check("lu stall", 64'(dut_ctl()), 64'(6'b000100));
        tick("lu stall");
        check("lu stall_cnt", 64'(bus.stall_cnt), 64'(1));
        clear_inputs();
        #4;
        check("lu release", 64'(dut_ctl()), 64'(6'b110000));
        tick("lu release");
        bus.ex_memread = 1'b1;
        bus.id_uses_rs = 1'b1;
        #4;
        check("lu rd0", 64'(dut_ctl()), 64'(6'b110000));
        tick("lu rd0");
        check("lu rd0 stall_cnt", 64'(bus.stall_cnt), 64'(1));
        clear_inputs();

        // Redirect and load-use together: redirect only.
        do_init(2'b00);
        bus.ex_memread   = 1'b1;
        bus.ex_rd        = 5'd5;
        bus.id_rt        = 5'd5;
        bus.id_uses_rt   = 1'b1;
        bus.ex_is_branch = 1'b1;
        bus.ex_taken     = 1'b1;
        #4;
        check("redir+lu", 64'(dut_ctl()), 64'(6'b111110));
        tick("redir+lu");
        check("redir+lu stall_cnt", 64'(bus.stall_cnt), 64'(0));
        check("redir+lu flush_cnt", 64'(bus.flush_cnt), 64'(2));
        clear_inputs();

        // Asynchronous reset in the middle of a stall, then reserved strategy 11.
        do_init(2'b01);
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd12;
        bus.id_rs      = 5'd12;
        bus.id_uses_rs = 1'b1;
        #4;
        tick("rst lu");
        clear_inputs();
        #2;
        rst = 1'b0;
        #1;
        check("rst mid-stall ctl", 64'({dut_ctl(), bus.mode}), 64'(8'b0011_0000));
        check("rst mid-stall counters", 64'(bus.cycle_cnt | bus.stall_cnt | bus.flush_cnt),
              64'(0));
        do_init(2'b11);
        check("strategy 11 mode", 64'(bus.mode), 64'(0));
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd12;
        bus.id_rs      = 5'd12;
        bus.id_uses_rs = 1'b1;
        #4;
        check("post-rst stall", 64'(dut_ctl()), 64'(6'b000100));
        tick("post-rst stall");
        clear_inputs();

        // Random traffic in every strategy against the model.
        for (int m = 0; m < 4; m++) begin
            do_init(2'(m));
            for (int c = 0; c < 400; c++) begin
                int r;
                r = int'($urandom_range(0, 7));
                bus.strategy     = 2'($urandom_range(0, 3));
                bus.id_is_branch = (r < 2);
                bus.id_is_jump   = (r == 2);
                bus.id_rs        = 5'($urandom_range(0, 3));
                bus.id_rt        = 5'($urandom_range(0, 3));
                bus.id_uses_rs   = 1'($urandom_range(0, 1));
                bus.id_uses_rt   = 1'($urandom_range(0, 1));
                bus.ex_memread   = ($urandom_range(0, 2) == 0);
                bus.ex_rd        = 5'($urandom_range(0, 3));
                bus.ex_is_branch = (m_mode == 2'd1) ? m_pred_ex : ($urandom_range(0, 3) == 0);
                bus.ex_taken     = 1'($urandom_range(0, 1));
                #4;
                tick($sformatf("rand m%0d c%0d", m, c));
            end
            clear_inputs();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
